board_move_collector: RTL
=========================

# board_move_collector

Board-level stage directly downstream of the eight column units. Once each column reports done, it drains that column's 160-bit move FIFO and unpacks each word into individual 19-bit moves. The moves leave on a single valid/ready stream toward the move-selection logic. The block also counts the moves it emits and signals when every column has been drained.

## Interface
- NCOL, 8, number of columns drained (fixed board width)
- SLOTS, 8, move slots per column FIFO word
- SLOT_W, 20, slot width: [19] slot-valid, [18:0] move
- MOVE_W, 19, move width: [18:12] flags, [11:6] from, [5:0] to
- CNT_W, 8, width of move counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new collection pass; ignored while busy
- col_done  in  NCOL  per-column done level
- col_empty  in  NCOL  per-column FIFO empty flag
- col_data  in  NCOL*160  column FIFO outputs; column c occupies [160c+159:160c]
- col_rden  out  NCOL  per-column FIFO read enable, one-hot or zero
- move_out  out  MOVE_W  current move
- move_valid  out  1  move_out holds a move
- move_ready  in  1  consumer accepts move_out this cycle
- move_count  out  CNT_W  moves emitted in the current pass, saturating at all-ones
- busy  out  1  a pass is in progress
- done  out  1  level; all columns drained; cleared by the next accepted start

## Operation
- States: IDLE, SCAN, READ, LATCH, UNPACK, DONE.
- IDLE: an accepted start clears the drained mask, move_count and done, then goes to SCAN.
- SCAN: pick the lowest-index column c with col_done[c]=1 and drained[c]=0, then go to READ. If every column is drained, go to DONE. Otherwise stay in SCAN.
- READ: if col_empty[c]=1, set drained[c] and return to SCAN. Otherwise assert col_rden[c] for exactly one cycle and go to LATCH.
- LATCH: FIFO data is valid one cycle after rden. Capture col_data slice c into the word buffer, set slot pointer to 0, go to UNPACK.
- UNPACK: examine slot[ptr].
  - Slot-valid=0: skip it, using one cycle.
  - Slot-valid=1: present the move and wait for the handshake.
  - After slot SLOTS-1 completes, return to READ on the same column.
- DONE: done=1, busy=0. On start, go to SCAN with state cleared as in IDLE.
- busy=1 in SCAN, READ, LATCH and UNPACK.
- move_count increments on each accepted transfer (move_valid & move_ready) and saturates at 2^CNT_W-1.
- A column whose done drops mid-pass keeps its drained bit; the pass does not revisit it.

## Timing
- Reset values: col_rden=0, move_out=0, move_valid=0, move_count=0, busy=0, done=0, state IDLE.
- All outputs are registered.
- move_valid rises the cycle after UNPACK lands on a valid slot.
- move_out and move_valid hold stable while move_valid & ~move_ready.
- A transfer completes on the edge where valid and ready are both high. The next valid slot can be presented the following cycle, giving 1 move/cycle with ready held high.
- Per-word overhead: READ + LATCH = 2 cycles, plus 1 cycle per skipped slot.
- Empty column, col_done already high: SCAN→READ→SCAN costs 2 cycles.
- start while busy is ignored. start in the same cycle as the DONE entry is honoured on the next cycle.
- Asserting reset mid-pass immediately clears all state; an in-flight rden is dropped.

## Configuration
- COLLECT_DROP_INVALID_EN defined: moves with flag bit [18] (invalid) set are skipped like empty slots. They are neither emitted nor counted.
- Not defined: every slot-valid move is emitted and counted regardless of flag [18].

## Structure
- Shared package chess_move_pkg holds:
  - MOVE_W, SLOT_W, SLOTS
  - flag bit indices (INVALID=18, PROMOTE=17, PAWN=16, PAWN2=15, EP=14, CASTLE=13, CAPTURE=12)
  - the collector state enum
- One sub-module, move_slot_unpacker. It owns the 160-bit word buffer, the slot pointer and the valid/ready output register. It reports word-exhausted to the parent FSM.
- The parent owns column selection, rden generation, the drained mask, the counter and done.

## Test plan
- Only column 3 done, one word with slots 0 and 5 valid (moves 0x0_0C1C, 0x4_0D25), ready=1 → exactly those two moves emitted in that order; move_count=2; done rises.
- Columns 0 and 7 done simultaneously → column 0 fully drained before any col_rden[7]; col_rden never has more than one bit set.
- move_ready held low for 5 cycles while a move is presented → move_out stable, move_valid stays 1, count unchanged until ready rises.
- Word with all slots flagged invalid (bit 18), with and without COLLECT_DROP_INVALID_EN → 0 vs 8 moves emitted; move_count 0 vs 8.
- 260 moves across columns → move_count saturates at 255; all 260 moves still emitted.
- reset asserted during UNPACK → all outputs read 0 in the same cycle; a new start runs a full clean pass.

Source files
------------

// File: rtl/chess_move_pkg.sv
// Shared move/slot layouts, board constants and the collector state encoding.
package chess_move_pkg;

    localparam int unsigned NCOL   = 8;
    localparam int unsigned SLOTS  = 8;
    localparam int unsigned SLOT_W = 20;
    localparam int unsigned MOVE_W = 19;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WORD_W = SLOTS * SLOT_W;
    localparam int unsigned COL_W  = $clog2(NCOL);
    localparam int unsigned IDX_W  = $clog2(SLOTS);
    localparam int unsigned PTR_W  = $clog2(SLOTS + 1);

    // Flag bit positions within a MOVE_W-bit move
    localparam int unsigned FLAG_INVALID = 18;
    localparam int unsigned FLAG_PROMOTE = 17;
    localparam int unsigned FLAG_PAWN    = 16;
    localparam int unsigned FLAG_PAWN2   = 15;
    localparam int unsigned FLAG_EP      = 14;
    localparam int unsigned FLAG_CASTLE  = 13;
    localparam int unsigned FLAG_CAPTURE = 12;

    typedef struct packed {
        logic [6:0] flags;
        logic [5:0] from_sq;
        logic [5:0] to_sq;
    } move_t;

    typedef struct packed {
        logic  vld;
        move_t mv;
    } slot_t;

    // Slot s occupies bits [SLOT_W*s +: SLOT_W] of a FIFO word
    typedef slot_t [SLOTS-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_READ,
        ST_LATCH,
        ST_UNPACK,
        ST_DONE
    } collect_state_t;

endpackage

// File: rtl/move_slot_unpacker.sv
// Holds one column FIFO word and walks its slots onto a valid/ready move register.
// Optional build macro: COLLECT_DROP_INVALID_EN (skip moves carrying the invalid flag).
module move_slot_unpacker
    import chess_move_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_run,
    input  logic              i_ready,
    output logic [MOVE_W-1:0] o_move,
    output logic              o_valid,
    output logic              o_exhausted_c
);

    word_t             r_buf;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_valid;
    logic [MOVE_W-1:0] r_move;

    slot_t             w_slot;
    logic [MOVE_W-1:0] w_move_bits;
    logic              w_free;
    logic              w_take;

    // The output register is free when empty or being accepted this cycle
    always_comb begin
        w_slot      = r_buf[r_ptr[IDX_W-1:0]];
        w_move_bits = w_slot.mv;
        w_free      = ~r_valid | i_ready;
`ifdef COLLECT_DROP_INVALID_EN
        w_take      = w_slot.vld & ~w_move_bits[FLAG_INVALID];
`else
        w_take      = w_slot.vld;
`endif
        o_exhausted_c = (r_ptr == PTR_W'(SLOTS)) & w_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_move  <= '0;
        end else if (i_load) begin
            r_buf   <= i_word;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else if (i_run && w_free) begin
            if (r_ptr == PTR_W'(SLOTS)) begin
                r_valid <= 1'b0;
            end else begin
                r_ptr   <= r_ptr + PTR_W'(1);
                r_valid <= w_take;
                if (w_take) begin
                    r_move <= w_move_bits;
                end
            end
        end
    end

    assign o_move  = r_move;
    assign o_valid = r_valid;

endmodule

// File: rtl/board_move_collector.sv
// Drains every done column's move FIFO and streams the unpacked moves to move selection.
// Optional build macro: COLLECT_DROP_INVALID_EN (moves flagged invalid are neither emitted nor counted).
module board_move_collector
    import chess_move_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NCOL-1:0]        col_done,
    input  logic [NCOL-1:0]        col_empty,
    input  logic [NCOL*WORD_W-1:0] col_data,
    output logic [NCOL-1:0]        col_rden,
    output logic [MOVE_W-1:0]      move_out,
    output logic                   move_valid,
    input  logic                   move_ready,
    output logic [CNT_W-1:0]       move_count,
    output logic                   busy,
    output logic                   done
);

    collect_state_t    r_state;
    collect_state_t    w_next_state;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_next_col;
    logic [NCOL-1:0]   r_drained;
    logic [NCOL-1:0]   w_next_drained;
    logic [NCOL-1:0]   r_rden;
    logic [NCOL-1:0]   w_next_rden;
    logic [CNT_W-1:0]  r_count;
    logic              r_busy;
    logic              r_done;

    logic [NCOL-1:0]   w_cand;
    logic [COL_W-1:0]  w_pick_col;
    logic              w_pick_found;
    logic              w_clear;
    logic              w_load;
    logic              w_run;
    logic              w_exhausted;
    logic              w_xfer;
    logic [WORD_W-1:0] w_word;

    assign w_cand = col_done & ~r_drained;
    assign w_word = col_data[r_col*WORD_W +: WORD_W];
    assign w_run  = (r_state == ST_UNPACK);
    assign w_xfer = move_valid & move_ready;

    // Lowest-index column that is done and not yet drained
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_col   = '0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_pick_found = 1'b1;
                w_pick_col   = COL_W'(i);
            end
        end
    end

    // Read enable is registered on entry to READ so the word is on col_data during LATCH
    always_comb begin
        w_next_state   = r_state;
        w_next_col     = r_col;
        w_next_drained = r_drained;
        w_next_rden    = '0;
        w_clear        = 1'b0;
        w_load         = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clear        = 1'b1;
                    w_next_drained = '0;
                    w_next_state   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (&r_drained) begin
                    w_next_state = ST_DONE;
                end else if (w_pick_found) begin
                    w_next_col   = w_pick_col;
                    w_next_rden  = (NCOL'(1) << w_pick_col) & ~col_empty;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (r_rden == '0) begin
                    w_next_drained[r_col] = 1'b1;
                    w_next_state          = ST_SCAN;
                end else begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_load       = 1'b1;
                w_next_state = ST_UNPACK;
            end
            ST_UNPACK: begin
                if (w_exhausted) begin
                    w_next_rden  = (NCOL'(1) << r_col) & ~col_empty;
                    w_next_state = ST_READ;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_drained <= '0;
            r_rden    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_col     <= w_next_col;
            r_drained <= w_next_drained;
            r_rden    <= w_next_rden;
            r_busy    <= (w_next_state == ST_SCAN)  || (w_next_state == ST_READ) ||
                         (w_next_state == ST_LATCH) || (w_next_state == ST_UNPACK);
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    // Saturating count of accepted moves in the current pass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    move_slot_unpacker u_unpacker (
        .clk           (clk),
        .rst_n         (reset),
        .i_load        (w_load),
        .i_word        (w_word),
        .i_run         (w_run),
        .i_ready       (move_ready),
        .o_move        (move_out),
        .o_valid       (move_valid),
        .o_exhausted_c (w_exhausted)
    );

    assign col_rden   = r_rden;
    assign move_count = r_count;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
